handler: RTL and testbench

HANDLER -- requirements
Module: handler

---
 rtl/handler_pkg.sv | 26 ++
 rtl/handler_lfsr.sv | 36 +++
 rtl/handler.sv | 191 +++++++++++++++++++
 tb/tb_handler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handler_pkg.sv
// Shared definitions for the handler block: default widths, LFSR seed and
// feedback taps, and the controller state enumeration.
package handler_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [3:0] {
        IDLE,
        SWR,
        SRD,
        SWAIT,
        RDA,
        WTA,
        RDB,
        WTB,
        WRA,
        WRB,
        DONE
    } state_e;

endpackage

// File: rtl/handler_lfsr.sv
// 8-bit Fibonacci LFSR used to pick the physical slot for each shuffled access.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset, loads LFSR_SEED
//   step_i  - advance the sequence by one position this cycle
//   value_o - current LFSR value
module handler_lfsr
    import handler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step_i,
    output logic [7:0] value_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/handler.sv
// Memory request handler with two modes: sequential pass-through, and an
// oblivious mode that relocates each accessed block to an LFSR-chosen slot
// (swapping it with that slot's occupant) on every access.
// Ports:
//   clk, reset                  - clock and synchronous active-high reset
//   enabled                     - 1 = shuffled mode, 0 = pass-through
//   rw                          - 1 = write, 0 = read
//   original_address/_data      - logical request, held by requester until o_oe
//   o_we / o_re                 - write / read request in progress
//   o_oe                        - one-cycle completion pulse
//   requested_address/_data     - completed request address and data
//   random_address              - memory write address
//   random_requested_address    - memory read address
//   random_write_data           - memory write data
//   random_read_data            - memory read data (one cycle after re/oe)
//   we / re / oe                - memory strobes
module handler
    import handler_pkg::*;
#(
    parameter int unsigned ADDR_W = handler_pkg::ADDR_W,
    parameter int unsigned DATA_W = handler_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enabled,
    input  logic              rw,
    input  logic [ADDR_W-1:0] original_address,
    input  logic [DATA_W-1:0] original_data,
    output logic              o_we,
    output logic              o_re,
    output logic              o_oe,
    output logic [ADDR_W-1:0] requested_address,
    output logic [DATA_W-1:0] requested_data,
    output logic [ADDR_W-1:0] random_address,
    output logic [ADDR_W-1:0] random_requested_address,
    output logic [DATA_W-1:0] random_write_data,
    input  logic [DATA_W-1:0] random_read_data,
    output logic              we,
    output logic              re,
    output logic              oe
);

    state_e state_q, state_d;

    logic              oram_q, rw_q;
    logic [ADDR_W-1:0] addr_q, p_q, r_q, b_q;
    logic [DATA_W-1:0] wdata_q, da_q, db_q;

    logic [ADDR_W-1:0] pos_q [2**ADDR_W];  // logical -> physical
    logic [ADDR_W-1:0] inv_q [2**ADDR_W];  // physical -> logical

    logic [7:0]        lfsr_value;
    logic              lfsr_step;
    logic [ADDR_W-1:0] r_now;
    logic              same_slot;

    assign lfsr_step = (state_q == IDLE) && enabled;
    assign r_now     = ADDR_W'(lfsr_value);
    assign same_slot = (r_q == p_q);

    handler_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step_i  (lfsr_step),
        .value_o (lfsr_value)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = enabled ? RDA : (rw ? SWR : SRD);
            SWR:     state_d = DONE;
            SRD:     state_d = SWAIT;
            SWAIT:   state_d = DONE;
            RDA:     state_d = WTA;
            WTA:     state_d = same_slot ? WRA : RDB;
            RDB:     state_d = WTB;
            WTB:     state_d = WRA;
            WRA:     state_d = same_slot ? DONE : WRB;
            WRB:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are gated by reset so an access aborted mid-write never
    // commits a write on the reset edge.
    always_comb begin
        we   = 1'b0;
        re   = 1'b0;
        oe   = 1'b0;
        o_we = 1'b0;
        o_re = 1'b0;
        o_oe = 1'b0;
        if (!reset) begin
            case (state_q)
                SWR, WRA, WRB: we = 1'b1;
                SRD, RDA, RDB: begin
                    re = 1'b1;
                    oe = 1'b1;
                end
                default: ;
            endcase
            o_we = (state_q != IDLE) && rw_q;
            o_re = (state_q != IDLE) && !rw_q;
            o_oe = (state_q == DONE);
        end
    end

    // Memory address/data registers are loaded on the edge entering the
    // state that uses them, so they hold their value once the strobe drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                  <= IDLE;
            oram_q                   <= 1'b0;
            rw_q                     <= 1'b0;
            addr_q                   <= '0;
            p_q                      <= '0;
            r_q                      <= '0;
            b_q                      <= '0;
            wdata_q                  <= '0;
            da_q                     <= '0;
            db_q                     <= '0;
            requested_address        <= '0;
            requested_data           <= '0;
            random_address           <= '0;
            random_requested_address <= '0;
            random_write_data        <= '0;
            for (int unsigned i = 0; i < 2**ADDR_W; i++) begin
                pos_q[i] <= ADDR_W'(i);
                inv_q[i] <= ADDR_W'(i);
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    oram_q  <= enabled;
                    rw_q    <= rw;
                    addr_q  <= original_address;
                    wdata_q <= original_data;
                    p_q     <= pos_q[original_address];
                    r_q     <= r_now;
                    b_q     <= inv_q[r_now];
                    if (enabled) begin
                        random_requested_address <= pos_q[original_address];
                    end else if (rw) begin
                        random_address    <= original_address;
                        random_write_data <= original_data;
                    end else begin
                        random_requested_address <= original_address;
                    end
                end
                WTA: begin
                    da_q <= random_read_data;
                    if (same_slot) begin
                        random_address    <= p_q;
                        random_write_data <= rw_q ? wdata_q : random_read_data;
                    end else begin
                        random_requested_address <= r_q;
                    end
                end
                WTB: begin
                    db_q              <= random_read_data;
                    random_address    <= r_q;
                    random_write_data <= rw_q ? wdata_q : da_q;
                end
                WRA: begin
                    if (!same_slot) begin
                        random_address    <= p_q;
                        random_write_data <= db_q;
                    end
                end
                DONE: begin
                    // With r == p these collapse to identity rewrites.
                    if (oram_q) begin
                        pos_q[addr_q] <= r_q;
                        pos_q[b_q]    <= p_q;
                        inv_q[r_q]    <= addr_q;
                        inv_q[p_q]    <= b_q;
                    end
                end
                default: ;
            endcase
            if (state_d == DONE) begin
                requested_address <= addr_q;
                requested_data    <= rw_q ? wdata_q : (oram_q ? da_q : random_read_data);
            end
        end
    end

endmodule

// File: tb/tb_handler.sv
module tb_handler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enabled = 1'b0;
    logic        rw = 1'b0;
    logic [7:0]  original_address = '0;
    logic [31:0] original_data = '0;
    logic        o_we, o_re, o_oe;
    logic [7:0]  requested_address;
    logic [31:0] requested_data;
    logic [7:0]  random_address, random_requested_address;
    logic [31:0] random_write_data;
    logic [31:0] random_read_data = '0;
    logic        we, re, oe;

    int errors = 0;
    int checks = 0;
    int strobe_err = 0;

    handler #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enabled                  (enabled),
        .rw                       (rw),
        .original_address         (original_address),
        .original_data            (original_data),
        .o_we                     (o_we),
        .o_re                     (o_re),
        .o_oe                     (o_oe),
        .requested_address        (requested_address),
        .requested_data           (requested_data),
        .random_address           (random_address),
        .random_requested_address (random_requested_address),
        .random_write_data        (random_write_data),
        .random_read_data         (random_read_data),
        .we                       (we),
        .re                       (re),
        .oe                       (oe)
    );

    always #5 clk = ~clk;

    // ExampleRAM plus an access recorder
    logic [31:0] ram [256] = '{default: '0};
    logic [7:0]  rd_q[$];
    logic [7:0]  wr_q[$];

    always @(posedge clk) begin
        if (we) begin
            ram[random_address] <= random_write_data;
            wr_q.push_back(random_address);
        end
        if (re && oe) begin
            random_read_data <= ram[random_requested_address];
            rd_q.push_back(random_requested_address);
        end
    end

    always @(negedge clk) if (re !== oe) strobe_err++;

    // Reference model: logical contents plus the logical/physical permutation
    logic [31:0] L    [256];
    logic [7:0]  mpos [256];
    logic [7:0]  minv [256];
    logic [7:0]  mlfsr;
    logic        lat1_we, lat1_re;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // After reset the maps are identity, so logical x now names whatever
    // block physically sits at slot x.
    task automatic model_reset();
        logic [31:0] nl [256];
        for (int i = 0; i < 256; i++) nl[i] = L[minv[i]];
        for (int i = 0; i < 256; i++) begin
            L[i]    = nl[i];
            mpos[i] = 8'(i);
            minv[i] = 8'(i);
        end
        mlfsr = 8'hA5;
    endtask

    // Called #1 after an edge that leaves the DUT idle for the coming cycle.
    task automatic run_req(input logic en, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input bit scramble,
                           output int lat, output logic [7:0] ra, output logic [31:0] rd);
        bit found = 0;
        reset = 1'b0;
        enabled = en;
        rw = w;
        original_address = a;
        original_data = d;
        rd_q.delete();
        wr_q.delete();
        lat = 0;
        ra = '0;
        rd = '0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            lat++;
            if (scramble && lat == 1) begin
                #1;
                enabled = 1'($urandom);
                rw = 1'($urandom);
                original_address = 8'($urandom);
                original_data = $urandom;
            end
            @(negedge clk);
            if (lat == 1) begin
                lat1_we = o_we;
                lat1_re = o_re;
            end
            if (o_oe === 1'b1) begin
                ra = requested_address;
                rd = requested_data;
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no o_oe within 20 cycles, want a completion pulse");
            lat = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic oram_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                               input bit scramble, input string tag);
        logic [7:0]  p, r, b, ra;
        logic [31:0] exp_d, old_b, rd;
        int          lat;
        bit          same;
        p = mpos[a];
        r = mlfsr;
        b = minv[r];
        same = (p == r);
        exp_d = w ? d : L[a];
        old_b = L[b];
        run_req(1'b1, w, a, d, scramble, lat, ra, rd);
        checks++;
        if (lat !== (same ? 4 : 7)) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, same ? 4 : 7);
        end
        checks++;
        if (ra !== a || rd !== exp_d) begin
            errors++;
            $display("FAIL %s result: got addr %h data %h want addr %h data %h", tag, ra, rd, a, exp_d);
        end
        checks++;
        if ({lat1_we, lat1_re} !== {w, ~w}) begin
            errors++;
            $display("FAIL %s req_flags: got o_we %b o_re %b want %b %b", tag, lat1_we, lat1_re, w, ~w);
        end
        checks++;
        if (same ? (rd_q.size() != 1 || rd_q[0] !== p)
                 : (rd_q.size() != 2 || rd_q[0] !== p || rd_q[1] !== r)) begin
            errors++;
            $display("FAIL %s reads: got %p want p=%h r=%h same=%0d", tag, rd_q, p, r, same);
        end
        checks++;
        if (same ? (wr_q.size() != 1 || wr_q[0] !== p)
                 : (wr_q.size() != 2 || wr_q[0] !== r || wr_q[1] !== p)) begin
            errors++;
            $display("FAIL %s writes: got %p want r=%h p=%h same=%0d", tag, wr_q, r, p, same);
        end
        checks++;
        if (ram[r] !== exp_d || (!same && ram[p] !== old_b)) begin
            errors++;
            $display("FAIL %s mem: got [r]=%h [p]=%h want %h %h", tag, ram[r], ram[p], exp_d, old_b);
        end
        if (w) L[a] = d;
        mpos[a] = r;
        mpos[b] = p;
        minv[r] = a;
        minv[p] = b;
        mlfsr = lfsr_next(mlfsr);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) L[i] = '0;
        for (int i = 0; i < 256; i++) minv[i] = 8'(i);
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_we, o_re, o_oe, we, re, oe, requested_address, requested_data,
             random_address, random_requested_address, random_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we%b re%b oe%b ra%h rd%h wa%h rra%h wd%h want all zero",
                     we, re, oe, requested_address, requested_data, random_address,
                     random_requested_address, random_write_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_seq();
        int lat;
        logic [7:0] ra;
        logic [31:0] rd;
        run_req(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, lat, ra, rd);
        L[minv[8'h10]] = 32'hDEADBEEF;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL seq_wr_latency: got %0d want 2", lat); end
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== 8'h10 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL seq_wr_access: got writes %p reads %p want one write at 10", wr_q, rd_q);
        end
        checks++;
        if (ra !== 8'h10 || rd !== 32'hDEADBEEF || lat1_we !== 1'b1) begin
            errors++;
            $display("FAIL seq_wr_result: got %h %h o_we %b want 10 deadbeef 1", ra, rd, lat1_we);
        end
        run_req(1'b0, 1'b0, 8'h10, 32'h0, 1'b0, lat, ra, rd);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL seq_rd_latency: got %0d want 3", lat); end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 8'h10 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL seq_rd_access: got reads %p writes %p want one read at 10", rd_q, wr_q);
        end
        checks++;
        if (ra !== 8'h10 || rd !== 32'hDEADBEEF || lat1_re !== 1'b1) begin
            errors++;
            $display("FAIL seq_rd_result: got %h %h o_re %b want 10 deadbeef 1", ra, rd, lat1_re);
        end
    endtask

    task automatic test_lfsr_seq();
        for (int k = 0; k < 4; k++) oram_access(1'b0, 8'h10, 32'h0, 1'b0, "lfsr_seq");
    endtask

    task automatic test_oram_fill();
        for (int a = 0; a < 16; a++) oram_access(1'b1, 8'(a), 32'(a * 3), 1'b0, "fill_wr");
        for (int a = 0; a < 16; a++) oram_access(1'b0, 8'(a), 32'h0, 1'b0, "fill_rd");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++)
            oram_access(1'($urandom), 8'($urandom_range(15, 0)), $urandom,
                        1'($urandom), "mix");
    endtask

    task automatic test_same_slot();
        logic [7:0] a1, a2;
        a1 = minv[mlfsr];
        oram_access(1'b1, a1, $urandom, 1'b0, "same_wr");
        a2 = minv[mlfsr];
        oram_access(1'b0, a2, 32'h0, 1'b0, "same_rd");
        oram_access(1'b0, a1, 32'h0, 1'b0, "after_same");
    endtask

    task automatic test_reset_abort();
        logic [7:0]  a, x, ra;
        logic [31:0] rd;
        int          lat;
        bit          found = 0;
        a = 8'($urandom_range(15, 0));
        reset = 1'b0;
        enabled = 1'b1;
        rw = 1'b0;
        original_address = a;
        original_data = '0;
        rd_q.delete();
        wr_q.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (we === 1'b1) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach_write: got no we within 20 cycles, want one"); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        x = 8'($urandom);
        enabled = 1'b0;
        rw = 1'b0;
        original_address = x;
        #1;
        checks++;
        if ({we, re, oe, o_oe, o_we, o_re} !== 6'b0) begin
            errors++;
            $display("FAIL abort_strobes: got we%b re%b oe%b o_oe%b o_we%b o_re%b want all 0",
                     we, re, oe, o_oe, o_we, o_re);
        end
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL abort_writes: got %p want no writes", wr_q);
        end
        model_reset();
        run_req(1'b0, 1'b0, x, 32'h0, 1'b0, lat, ra, rd);
        checks++;
        if (lat !== 3 || ra !== x || rd !== L[x]) begin
            errors++;
            $display("FAIL abort_seq_read: got lat %0d %h %h want 3 %h %h", lat, ra, rd, x, L[x]);
        end
        oram_access(1'b0, 8'($urandom_range(15, 0)), 32'h0, 1'b0, "post_reset");
    endtask

    task automatic test_strobe_pairing();
        checks++;
        if (strobe_err !== 0) begin
            errors++;
            $display("FAIL re_oe_pairing: got %0d cycles with re != oe want 0", strobe_err);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_lfsr_seq();
        test_oram_fill();
        test_back_to_back();
        test_same_slot();
        test_reset_abort();
        test_strobe_pairing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
